// File: rtl/uart_mmio_bridge_pkg.sv
// Shared MMIO map for the UART bridge: address constants and a register-select decode.
package uart_mmio_bridge_pkg;

  localparam logic [31:0] ADDR_TX_STATUS = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX_DATA   = 32'h8000_0008;
  localparam logic [31:0] ADDR_RX_DATA   = 32'h8000_000C;
  localparam logic [31:0] ADDR_CYCLE     = 32'h8000_0010;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TX_STATUS,
    REG_RX_STATUS,
    REG_TX_DATA,
    REG_RX_DATA,
    REG_CYCLE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      ADDR_TX_STATUS: sel = REG_TX_STATUS;
      ADDR_RX_STATUS: sel = REG_RX_STATUS;
      ADDR_TX_DATA:   sel = REG_TX_DATA;
      ADDR_RX_DATA:   sel = REG_RX_DATA;
      ADDR_CYCLE:     sel = REG_CYCLE;
      default:        sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// Bundle of the bridge's memory-stage bus and UART byte handshakes.
interface uart_mmio_bridge_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        WEUART;
  logic        REUART;
  logic [31:0] ReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;

  modport master (
    output Address, WriteData, WEUART, REUART, TxReady, RxData, RxValid,
    input  ReadData, TxData, TxValid, RxReady
  );

  modport slave (
    input  Address, WriteData, WEUART, REUART, TxReady, RxData, RxValid,
    output ReadData, TxData, TxValid, RxReady
  );
endinterface

// File: rtl/mmio_rx_fifo.sv
// Receive byte FIFO; power-of-two depth, pointers carry an extra wrap bit for full/empty.
module mmio_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// MMIO bridge between the CPU memory stage and a UART: TX holding register,
// RX FIFO, status registers and a free-running cycle counter.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        WEUART,
  input  logic        REUART,
  output logic [31:0] ReadData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady
);

  reg_sel_e    sel;
  logic        rd_en;
  logic        tx_wr, tx_accept;
  logic        rx_push, rx_pop;
  logic        rx_full, rx_empty;
  logic [7:0]  rx_head;

  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_overrun_q, tx_overrun_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] read_data_q, read_data_d;

  logic        unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  mmio_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (rx_push),
    .pop_i  (rx_pop),
    .data_i (RxData),
    .data_o (rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  assign TxValid  = tx_full_q;
  assign TxData   = tx_data_q;
  assign RxReady  = !rx_full;
  assign ReadData = read_data_q;

  always_comb begin
    sel          = decode_addr(Address);
    // A simultaneous write wins: the read has no side effects and returns 0.
    rd_en        = REUART && !WEUART;
    tx_wr        = WEUART && (sel == REG_TX_DATA);
    tx_accept    = tx_wr && (!tx_full_q || TxReady);
    rx_push      = RxValid && !rx_full;
    rx_pop       = rd_en && (sel == REG_RX_DATA) && !rx_empty;

    tx_full_d    = tx_full_q;
    tx_data_d    = tx_data_q;
    tx_overrun_d = tx_overrun_q;
    read_data_d  = read_data_q;

    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_data_d = WriteData[7:0];
    end else if (tx_full_q && TxReady) begin
      tx_full_d = 1'b0;
    end

    if (tx_wr && !tx_accept) begin
      tx_overrun_d = 1'b1;
    end else if (rd_en && (sel == REG_TX_STATUS)) begin
      tx_overrun_d = 1'b0;
    end

    cycle_d = (WEUART && (sel == REG_CYCLE)) ? '0 : cycle_q + 32'd1;

    if (REUART) begin
      read_data_d = '0;
      if (rd_en) begin
        case (sel)
          REG_TX_STATUS: read_data_d = {30'b0, tx_overrun_q, !tx_full_q};
          REG_RX_STATUS: read_data_d = {30'b0, rx_full, !rx_empty};
          REG_RX_DATA:   read_data_d = rx_empty ? '0 : {24'b0, rx_head};
          REG_CYCLE:     read_data_d = cycle_q;
          default:       read_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_full_q    <= 1'b0;
      tx_data_q    <= '0;
      tx_overrun_q <= 1'b0;
      cycle_q      <= '0;
      read_data_q  <= '0;
    end else begin
      tx_full_q    <= tx_full_d;
      tx_data_q    <= tx_data_d;
      tx_overrun_q <= tx_overrun_d;
      cycle_q      <= cycle_d;
      read_data_q  <= read_data_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: directed scenarios plus a randomized
// run compared against a queue-based transaction model.
module tb_uart_mmio_bridge;
  import uart_mmio_bridge_pkg::*;

  localparam int unsigned RX_DEPTH = 4;

  logic clk;
  logic reset;
  uart_mmio_bridge_if bus ();

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_full;
  logic [7:0]  m_byte;
  logic        m_ovr;
  logic [31:0] m_cnt;
  logic [31:0] m_rd;

  uart_mmio_bridge #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (bus.Address),
    .WriteData(bus.WriteData),
    .WEUART   (bus.WEUART),
    .REUART   (bus.REUART),
    .ReadData (bus.ReadData),
    .TxData   (bus.TxData),
    .TxValid  (bus.TxValid),
    .TxReady  (bus.TxReady),
    .RxData   (bus.RxData),
    .RxValid  (bus.RxValid),
    .RxReady  (bus.RxReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q.delete();
    m_full = 1'b0;
    m_byte = 8'h00;
    m_ovr  = 1'b0;
    m_cnt  = 32'd0;
    m_rd   = 32'd0;
  endfunction

  function automatic void model_step(input logic [31:0] a, input logic [31:0] wd,
                                     input logic we, input logic re, input logic txr,
                                     input logic rxv, input logic [7:0] rxd);
    logic rd;
    int   occ;
    rd  = re && !we;
    occ = m_q.size();
    if (re) begin
      m_rd = 32'd0;
      if (rd) begin
        if (a == ADDR_TX_STATUS) m_rd = {30'd0, m_ovr, !m_full};
        else if (a == ADDR_RX_STATUS) m_rd = {30'd0, occ == RX_DEPTH, occ != 0};
        else if (a == ADDR_RX_DATA && occ != 0) m_rd = {24'd0, m_q[0]};
        else if (a == ADDR_CYCLE) m_rd = m_cnt;
      end
    end
    if (we && a == ADDR_TX_DATA) begin
      if (!m_full || txr) begin
        m_byte = wd[7:0];
        m_full = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_full && txr) begin
      m_full = 1'b0;
    end
    if (rd && a == ADDR_TX_STATUS) m_ovr = 1'b0;
    if (rd && a == ADDR_RX_DATA && occ != 0) void'(m_q.pop_front());
    if (rxv && occ < RX_DEPTH) m_q.push_back(rxd);
    m_cnt = (we && a == ADDR_CYCLE) ? 32'd0 : m_cnt + 32'd1;
  endfunction

  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic txr, input logic rxv,
                       input logic [7:0] rxd);
    bus.Address   = a;
    bus.WriteData = wd;
    bus.WEUART    = we;
    bus.REUART    = re;
    bus.TxReady   = txr;
    bus.RxValid   = rxv;
    bus.RxData    = rxd;
    @(posedge clk);
    model_step(a, wd, we, re, txr, rxv, rxd);
    #1;
  endtask

  task automatic idle(input logic txr);
    cycle(32'h0, 32'h0, 1'b0, 1'b0, txr, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(a, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic txr);
    cycle(a, wd, 1'b1, 1'b0, txr, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.Address = '0; bus.WriteData = '0; bus.WEUART = 0; bus.REUART = 0;
    bus.TxReady = 0; bus.RxValid = 0; bus.RxData = '0;
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", bus.ReadData); end
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL reset_txvalid: got %b expected 0", bus.TxValid); end
    checks++; if (bus.TxData !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h expected 00", bus.TxData); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.RxReady !== 1'b1) begin errors++; $display("FAIL reset_rxready: got %b expected 1", bus.RxReady); end
    rd(ADDR_TX_STATUS);
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL reset_tx_status: got %h expected 00000001", bus.ReadData); end
    rd(ADDR_RX_STATUS);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL reset_rx_status: got %h expected 00000000", bus.ReadData); end
  endtask

  task automatic test_tx_basic();
    wr(ADDR_TX_DATA, 32'hFFFF_FF41, 1'b0);
    checks++; if (bus.TxValid !== 1'b1) begin errors++; $display("FAIL tx_valid_set: got %b expected 1", bus.TxValid); end
    checks++; if (bus.TxData !== 8'h41) begin errors++; $display("FAIL tx_data: got %h expected 41", bus.TxData); end
    idle(1'b0);
    checks++; if (bus.TxValid !== 1'b1) begin errors++; $display("FAIL tx_valid_hold: got %b expected 1", bus.TxValid); end
    idle(1'b1);
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL tx_valid_clear: got %b expected 0", bus.TxValid); end
  endtask

  task automatic test_tx_overrun();
    wr(ADDR_TX_DATA, 32'hA5, 1'b0);
    wr(ADDR_TX_DATA, 32'h5A, 1'b0);
    checks++; if (bus.TxData !== 8'hA5) begin errors++; $display("FAIL ovr_txdata_kept: got %h expected a5", bus.TxData); end
    rd(ADDR_TX_STATUS);
    checks++; if (bus.ReadData !== 32'h2) begin errors++; $display("FAIL ovr_status: got %h expected 00000002", bus.ReadData); end
    rd(ADDR_TX_STATUS);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL ovr_cleared: got %h expected 00000000", bus.ReadData); end
    idle(1'b1);
    // Full register with TxReady high in the same cycle accepts the new byte.
    wr(ADDR_TX_DATA, 32'h77, 1'b0);
    wr(ADDR_TX_DATA, 32'h88, 1'b1);
    checks++; if (bus.TxData !== 8'h88 || bus.TxValid !== 1'b1) begin errors++; $display("FAIL tx_replace: got %h/%b expected 88/1", bus.TxData, bus.TxValid); end
    rd(ADDR_TX_STATUS);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL tx_replace_no_ovr: got %h expected 00000000", bus.ReadData); end
    idle(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      b = 8'hC0 + 8'(i);
      wr(ADDR_TX_DATA, {24'h0, b}, 1'b1);
      checks++; if (bus.TxData !== b || bus.TxValid !== 1'b1) begin errors++; $display("FAIL b2b_tx_%0d: got %h/%b expected %h/1", i, bus.TxData, bus.TxValid, b); end
    end
    idle(1'b1);
    rd(ADDR_TX_STATUS);
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL b2b_status: got %h expected 00000001", bus.ReadData); end
  endtask

  task automatic test_rx_fifo();
    logic [7:0] exp_b;
    for (int i = 0; i < 4; i++)
      cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11 * 8'(i + 1));
    checks++; if (bus.RxReady !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b expected 0", bus.RxReady); end
    cycle(ADDR_RX_STATUS, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
    checks++; if (bus.ReadData !== 32'h3) begin errors++; $display("FAIL rx_full_status: got %h expected 00000003", bus.ReadData); end
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h11 * 8'(i + 1);
      rd(ADDR_RX_DATA);
      checks++; if (bus.ReadData !== {24'h0, exp_b}) begin errors++; $display("FAIL rx_pop_%0d: got %h expected %h", i, bus.ReadData, exp_b); end
    end
    rd(ADDR_RX_DATA);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rx_empty_read: got %h expected 00000000", bus.ReadData); end
  endtask

  task automatic test_push_pop();
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1);
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2);
    cycle(ADDR_RX_DATA, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3);
    checks++; if (bus.ReadData !== 32'hA1) begin errors++; $display("FAIL pp_head: got %h expected 000000a1", bus.ReadData); end
    rd(ADDR_RX_STATUS);
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL pp_status: got %h expected 00000001", bus.ReadData); end
    rd(ADDR_RX_DATA);
    checks++; if (bus.ReadData !== 32'hA2) begin errors++; $display("FAIL pp_second: got %h expected 000000a2", bus.ReadData); end
    rd(ADDR_RX_DATA);
    checks++; if (bus.ReadData !== 32'hA3) begin errors++; $display("FAIL pp_third: got %h expected 000000a3", bus.ReadData); end
    rd(ADDR_RX_DATA);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL pp_empty: got %h expected 00000000", bus.ReadData); end
  endtask

  task automatic test_priority_and_hold();
    rd(ADDR_TX_STATUS);
    idle(1'b0);
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL rd_hold: got %h expected 00000001", bus.ReadData); end
    cycle(ADDR_TX_DATA, 32'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL prio_read_zero: got %h expected 00000000", bus.ReadData); end
    checks++; if (bus.TxData !== 8'h3C || bus.TxValid !== 1'b1) begin errors++; $display("FAIL prio_write: got %h/%b expected 3c/1", bus.TxData, bus.TxValid); end
    idle(1'b1);
    rd(ADDR_TX_STATUS);
    rd(32'h8000_0014);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL bad_addr_read: got %h expected 00000000", bus.ReadData); end
    wr(32'h8000_0018, 32'h99, 1'b0);
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL bad_addr_write: got %b expected 0", bus.TxValid); end
  endtask

  task automatic test_counter();
    wr(ADDR_CYCLE, 32'h1234, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    rd(ADDR_CYCLE);
    checks++; if (bus.ReadData !== 32'd10) begin errors++; $display("FAIL cnt_value: got %0d expected 10", bus.ReadData); end
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    rd(ADDR_CYCLE);
    checks++; if (bus.ReadData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_preload: got %h expected ffffffff", bus.ReadData); end
    rd(ADDR_CYCLE);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL cnt_wrap: got %h expected 00000000", bus.ReadData); end
  endtask

  task automatic test_reset_mid();
    wr(ADDR_TX_DATA, 32'h6E, 1'b0);
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1);
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB2);
    rd(ADDR_RX_STATUS);
    checks++; if (bus.ReadData !== 32'h1 || bus.TxValid !== 1'b1) begin errors++; $display("FAIL mid_setup: got %h/%b expected 00000001/1", bus.ReadData, bus.TxValid); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.TxValid !== 1'b0 || bus.TxData !== 8'h00) begin errors++; $display("FAIL mid_tx_reset: got %h/%b expected 00/0", bus.TxData, bus.TxValid); end
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL mid_rd_reset: got %h expected 00000000", bus.ReadData); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.RxReady !== 1'b1) begin errors++; $display("FAIL mid_rxready: got %b expected 1", bus.RxReady); end
    rd(ADDR_RX_STATUS);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL mid_rx_status: got %h expected 00000000", bus.ReadData); end
  endtask

  task automatic test_random();
    logic [31:0] addrs [7];
    logic [31:0] a;
    logic        we, re;
    addrs[0] = ADDR_TX_STATUS; addrs[1] = ADDR_RX_STATUS; addrs[2] = ADDR_TX_DATA;
    addrs[3] = ADDR_RX_DATA;   addrs[4] = ADDR_CYCLE;     addrs[5] = 32'h8000_0014;
    addrs[6] = 32'h0000_0008;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      a  = addrs[$urandom_range(0, 6)];
      we = ($urandom_range(0, 3) == 0) && (a != ADDR_CYCLE || $urandom_range(0, 7) == 0);
      re = $urandom_range(0, 1) == 1;
      cycle(a, $urandom, we, re, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 8'($urandom));
      checks++;
      if (bus.TxValid !== m_full || bus.TxData !== m_byte ||
          bus.RxReady !== (m_q.size() < RX_DEPTH) || bus.ReadData !== m_rd) begin
        errors++;
        $display("FAIL rand_%0d: got tv=%b td=%h rr=%b rd=%h expected tv=%b td=%h rr=%b rd=%h",
                 i, bus.TxValid, bus.TxData, bus.RxReady, bus.ReadData,
                 m_full, m_byte, m_q.size() < RX_DEPTH, m_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overrun();
    test_back_to_back();
    test_rx_fifo();
    test_push_pop();
    test_priority_and_hold();
    test_counter();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_bridge.md
UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, receive FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Address, input, 32, memory-stage byte address.
REQ-005 SHALL have port WriteData, input, 32, store data; only bits [7:0] are used for UART writes.
REQ-006 SHALL have port WEUART, input, 1, store strobe from control, qualified by Address.
REQ-007 SHALL have port REUART, input, 1, load strobe from control, qualified by Address.
REQ-008 SHALL have port ReadData, output, 32, registered load result.
REQ-009 SHALL have port TxData, output, 8, byte offered to the UART transmitter.
REQ-010 SHALL have port TxValid, output, 1, TxData valid.
REQ-011 SHALL have port TxReady, input, 1, transmitter accepts the byte this cycle.
REQ-012 SHALL have port RxData, input, 8, byte from the UART receiver.
REQ-013 SHALL have port RxValid, input, 1, RxData valid.
REQ-014 SHALL have port RxReady, output, 1, bridge accepts RxData this cycle.

Function
REQ-015 SHALL decode 0x80000000 as TX status, 0x80000004 as RX status, 0x80000008 as TX data (write), 0x8000000C as RX data (read), 0x80000010 as cycle counter; any other address SHALL have no effect, and a read from it SHALL return 0.
REQ-016 SHALL implement a one-entry TX holding register with flag tx_full; TxValid SHALL equal tx_full, and TxData SHALL equal the held byte.
REQ-017 SHALL clear tx_full on a cycle where TxValid and TxReady are both high.
REQ-018 SHALL accept a write to TX data when tx_full is 0 or TxReady is 1 in the same cycle; the new byte loads and tx_full is 1 next cycle.
REQ-019 SHALL drop a write to TX data when tx_full is 1 and TxReady is 0; held byte unchanged; sticky tx_overrun set.
REQ-020 SHALL implement an RX FIFO of RX_DEPTH bytes; RxReady SHALL be 1 exactly when the FIFO is not full; a byte SHALL be pushed when RxValid and RxReady are both high.
REQ-021 SHALL pop the FIFO head on a read of RX data when the FIFO is non-empty; ReadData SHALL be {24'b0, head} in the next cycle.
REQ-022 SHALL return 0 for a read of RX data while empty, with no pop and no pointer change.
REQ-023 SHALL perform a push and a pop in the same cycle when the FIFO is neither full nor empty; occupancy SHALL be unchanged and FIFO order preserved.
REQ-024 SHALL wrap read and write pointers modulo RX_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or a count.
REQ-025 SHALL return {30'b0, tx_overrun, ~tx_full} for a TX status read, and {30'b0, rx_full, ~rx_empty} for an RX status read; reading TX status SHALL clear tx_overrun.
REQ-026 SHALL increment a 32-bit cycle counter every cycle, wrapping 0xFFFFFFFF to 0; a write to 0x80000010 SHALL load 0 and increment from the next cycle.
REQ-027 SHALL present every read result on ReadData exactly 1 cycle after REUART; ReadData SHALL hold its value otherwise.
REQ-028 SHALL give a write priority over a read when WEUART and REUART are both high; the read result SHALL be 0.

Reset
REQ-029 SHALL on reset low, asynchronously: ReadData 0, TxData 0, TxValid 0, tx_overrun 0, FIFO pointers 0 (RxReady goes to 1 after release), and cycle counter 0.
REQ-030 SHALL discard a byte held or in flight at reset assertion; the first transfer after release SHALL start from the empty state.

Structure
REQ-031 SHALL take the five MMIO address constants from a shared package/include used by control and this block.
REQ-032 SHALL implement the receive FIFO as sub-module mmio_rx_fifo (push/pop/full/empty), instantiated once.

Verification
REQ-033 SHALL cover: write 0x41 with TxReady=0 -> TxValid=1 and TxData=0x41; TxReady=1 for one cycle -> TxValid=0.
REQ-034 SHALL cover: two TX writes with TxReady=0 -> second dropped, TxData stays the first byte, TX status read returns 0x2, a further status read returns 0x0.
REQ-035 SHALL cover: push 0x11,0x22,0x33,0x44 (depth 4) -> RxReady=0 and RX status=0x3; a fifth RxValid is not accepted; four RX-data reads return 0x11,0x22,0x33,0x44 in order.
REQ-036 SHALL cover: RX-data read while empty -> ReadData=0 next cycle; a simultaneous push+pop at occupancy 2 -> occupancy stays 2.
REQ-037 SHALL cover: write counter, wait 10 cycles, read -> value 10 ±1 per the defined latency; preload via force to 0xFFFFFFFF -> next value 0.
REQ-038 SHALL cover: assert reset mid-transfer with TxValid=1 and FIFO holding 2 -> all outputs at reset values immediately, RX status=0 after release.
